// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the configurable UART receiver.
package uart_pkg;

   localparam int DEF_CLK_DIV     = 100;
   localparam int DEF_DATA_BITS   = 8;
   localparam int DEF_PARITY_EN   = 0;
   localparam int DEF_PARITY_ODD  = 0;
   localparam int DEF_STOP_BITS   = 1;
   localparam int DEF_SYNC_STAGES = 2;

   // Bits per frame for the default configuration: start + data + parity + stop.
   localparam int FRAME_BITS = 1 + DEF_DATA_BITS + DEF_PARITY_EN + DEF_STOP_BITS;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   // Expected parity bit for a zero-extended data word.
   function automatic logic parity_of(input logic [8:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, falling-edge detect, bit-period counter and 3-sample majority vote.
module uart_rx_sampler #(
   parameter int CLK_DIV     = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_r,
   input  logic rst_n,
   input  logic rx,
   input  logic run,
   output logic rxs,
   output logic fall,
   output logic sample_strobe,
   output logic bit_value
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] MID_M1   = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] MID      = CW'(CLK_DIV / 2);
   localparam logic [CW-1:0] MID_P1   = CW'(CLK_DIV / 2 + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs_d;
   logic                   s0;
   logic                   s1;
   logic [CW-1:0]          cnt;

   assign rxs  = sync[SYNC_STAGES-1];
   assign fall = rxs_d & ~rxs;

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '1;
         rxs_d <= 1'b1;
         s0    <= 1'b1;
         s1    <= 1'b1;
         cnt   <= '0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], rx};
         rxs_d <= rxs;
         // The edge-detect cycle itself is count 0, so the first counted cycle is 1.
         if (!run)
            cnt <= fall ? CW'(1) : '0;
         else if (cnt == CNT_LAST)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (cnt == MID_M1)
            s0 <= rxs;
         if (cnt == MID)
            s1 <= rxs;
      end
   end

   assign sample_strobe = run & (cnt == MID_P1);
   assign bit_value     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, data shift register and valid/ready holding register.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | checking the start bit; a bit that votes 1 was a glitch
// DATA   | shifting in data bits, LSB first
// PARITY | checking the parity bit
// STOP   | checking stop bits, delivering the word on the last one
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int PARITY_EN   = DEF_PARITY_EN,
   parameter int PARITY_ODD  = DEF_PARITY_ODD,
   parameter int STOP_BITS   = DEF_STOP_BITS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                 clk_r,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   rx_state_e            state;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_idx;
   logic                 perr_int;
   logic [8:0]           par_word;
   logic                 run;
   logic                 rxs;
   logic                 fall;
   logic                 strobe;
   logic                 bit_value;

   assign run  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
   assign busy = (state != IDLE);

   always_comb begin
      par_word                = '0;
      par_word[DATA_BITS-1:0] = shreg;
   end

   uart_rx_sampler #(
      .CLK_DIV     (CLK_DIV),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk_r         (clk_r),
      .rst_n         (rst_n),
      .rx            (rx),
      .run           (run),
      .rxs           (rxs),
      .fall          (fall),
      .sample_strobe (strobe),
      .bit_value     (bit_value)
   );

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_idx   <= '0;
         perr_int  <= 1'b0;
         rx_data   <= '0;
         rx_perr   <= 1'b0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (fall) begin
                  state    <= START;
                  bit_idx  <= '0;
                  perr_int <= 1'b0;
               end
            end
            START: begin
               if (strobe)
                  state <= bit_value ? IDLE : DATA;
            end
            DATA: begin
               if (strobe) begin
                  shreg <= {bit_value, shreg[DATA_BITS-1:1]};
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     state   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (strobe) begin
                  perr_int <= bit_value ^ parity_of(par_word, 1'(PARITY_ODD));
                  state    <= STOP;
               end
            end
            STOP: begin
               if (strobe) begin
                  if (!bit_value) begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end else if (bit_idx == LAST_STOP) begin
                     // Re-arm at mid stop bit so a back-to-back start edge is not missed.
                     state <= IDLE;
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shreg;
                        rx_perr  <= perr_int;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            BREAK: begin
               if (rxs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances cover 8N1, 8E1 and 7O2 framing.
module tb_uart_rx_cfg;

   localparam int DIV  = 16;
   localparam int SYNC = 2;

   logic clk_r = 1'b0;
   logic rst_n = 1'b0;
   logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;

   logic [7:0] rx_data0, rx_data1;
   logic [6:0] rx_data2;
   logic rx_perr0, rx_perr1, rx_perr2;
   logic rx_valid0, rx_valid1, rx_valid2;
   logic frame_err0, frame_err1, frame_err2;
   logic overrun0, overrun1, overrun2;
   logic busy0, busy1, busy2;

   always #5 clk_r = ~clk_r;

   uart_rx_cfg #(.CLK_DIV(DIV)) u_dut0 (
      .clk_r(clk_r), .rst_n(rst_n), .rx(rx0), .rx_data(rx_data0), .rx_perr(rx_perr0),
      .rx_valid(rx_valid0), .rx_ready(ready0), .frame_err(frame_err0), .overrun(overrun0), .busy(busy0));

   uart_rx_cfg #(.CLK_DIV(DIV), .PARITY_EN(1)) u_dut1 (
      .clk_r(clk_r), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_perr(rx_perr1),
      .rx_valid(rx_valid1), .rx_ready(ready1), .frame_err(frame_err1), .overrun(overrun1), .busy(busy1));

   uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
      .clk_r(clk_r), .rst_n(rst_n), .rx(rx2), .rx_data(rx_data2), .rx_perr(rx_perr2),
      .rx_valid(rx_valid2), .rx_ready(ready2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fe_cnt[3];
   int ov_cnt[3];
   int rise_cnt[3];
   int rise_cyc0 = 0;
   logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
   logic [9:0] q0[$], q1[$], q2[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_r) cyc++;

   // Accepted words are queued as {perr, zero-extended data}; flags are counted per cycle high.
   always @(negedge clk_r) begin
      #1;
      if (rx_valid0 && ready0) q0.push_back({rx_perr0, 1'b0, rx_data0});
      if (rx_valid1 && ready1) q1.push_back({rx_perr1, 1'b0, rx_data1});
      if (rx_valid2 && ready2) q2.push_back({rx_perr2, 2'b0, rx_data2});
      if (frame_err0) fe_cnt[0]++;
      if (frame_err1) fe_cnt[1]++;
      if (frame_err2) fe_cnt[2]++;
      if (overrun0) ov_cnt[0]++;
      if (overrun1) ov_cnt[1]++;
      if (overrun2) ov_cnt[2]++;
      if (rx_valid0 && !pv0) begin rise_cnt[0]++; rise_cyc0 = cyc; end
      if (rx_valid1 && !pv1) rise_cnt[1]++;
      if (rx_valid2 && !pv2) rise_cnt[2]++;
      pv0 = rx_valid0;
      pv1 = rx_valid1;
      pv2 = rx_valid2;
   end

   task automatic drive_bit(input int sel, input logic b);
      case (sel)
         0:       rx0 = b;
         1:       rx1 = b;
         default: rx2 = b;
      endcase
      repeat (DIV) @(negedge clk_r);
   endtask

   task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                             input bit par_en, input logic par_bit, input int nstop,
                             input logic stop_val);
      drive_bit(sel, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
      if (par_en) drive_bit(sel, par_bit);
      for (int i = 0; i < nstop; i++) drive_bit(sel, stop_val);
   endtask

   task automatic idle_bits(input int sel, input int n);
      for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
   endtask

   int fe0, ov0, rs0, t0, lat;
   logic [9:0] w;
   logic [6:0] exp_w[16];

   initial begin
      for (int i = 0; i < 3; i++) begin fe_cnt[i] = 0; ov_cnt[i] = 0; rise_cnt[i] = 0; end
      repeat (5) @(negedge clk_r);
      check("rst_valid", 32'(rx_valid0), 0);
      check("rst_data", 32'(rx_data0), 0);
      check("rst_busy", 32'(busy0), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_r);

      // 1: 8N1 0xA5, latency relative to the synchronised falling edge
      fe0 = fe_cnt[0]; ov0 = ov_cnt[0]; rs0 = rise_cnt[0];
      t0 = cyc;
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(0, 2);
      check("t1_qsize", 32'(q0.size()), 1);
      if (q0.size() > 0) begin
         w = q0.pop_front();
         check("t1_data", 32'(w[8:0]), 32'h0A5);
         check("t1_perr", 32'(w[9]), 0);
      end
      check("t1_rises", 32'(rise_cnt[0] - rs0), 1);
      check("t1_ferr", 32'(fe_cnt[0] - fe0), 0);
      check("t1_ovr", 32'(ov_cnt[0] - ov0), 0);
      lat = rise_cyc0 - (t0 + SYNC);
      check("t1_lat_in_window", 32'(lat >= DIV/2 + 9*DIV && lat <= DIV/2 + 2 + 9*DIV), 1);

      // 2: even parity, good then bad parity bit
      send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
      send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
      idle_bits(1, 2);
      check("t2_qsize", 32'(q1.size()), 2);
      if (q1.size() == 2) begin
         w = q1.pop_front();
         check("t2_w0_data", 32'(w[8:0]), 3);
         check("t2_w0_perr", 32'(w[9]), 0);
         w = q1.pop_front();
         check("t2_w1_data", 32'(w[8:0]), 3);
         check("t2_w1_perr", 32'(w[9]), 1);
      end
      check("t2_ferr", 32'(fe_cnt[1]), 0);

      // 3: low stop bit followed by a held-low break
      fe0 = fe_cnt[0]; rs0 = rise_cnt[0];
      send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
      check("t3_busy_low", 32'(busy0), 1);
      check("t3_ferr", 32'(fe_cnt[0] - fe0), 1);
      check("t3_rises", 32'(rise_cnt[0] - rs0), 0);
      rx0 = 1'b1;
      repeat (6) @(negedge clk_r);
      check("t3_busy_high", 32'(busy0), 0);
      check("t3_qsize", 32'(q0.size()), 0);
      idle_bits(0, 1);

      // 4: overrun with the holding register full
      ov0 = ov_cnt[0];
      ready0 = 1'b0;
      send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
      send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(0, 1);
      check("t4_valid", 32'(rx_valid0), 1);
      check("t4_hold", 32'(rx_data0), 32'h11);
      check("t4_ovr", 32'(ov_cnt[0] - ov0), 1);
      ready0 = 1'b1;
      repeat (2) @(negedge clk_r);
      check("t4_qsize", 32'(q0.size()), 1);
      if (q0.size() > 0) begin
         w = q0.pop_front();
         check("t4_consumed", 32'(w[8:0]), 32'h11);
      end
      check("t4_valid_drop", 32'(rx_valid0), 0);

      // 5: start-bit glitch, then reset mid-frame, then a clean frame
      fe0 = fe_cnt[0]; ov0 = ov_cnt[0]; rs0 = rise_cnt[0];
      rx0 = 1'b0;
      repeat (4) @(negedge clk_r);
      rx0 = 1'b1;
      repeat (3) @(negedge clk_r);
      check("t5_glitch_busy", 32'(busy0), 1);
      repeat (40) @(negedge clk_r);
      check("t5_glitch_idle", 32'(busy0), 0);
      check("t5_glitch_flags", 32'((fe_cnt[0] - fe0) + (ov_cnt[0] - ov0) + (rise_cnt[0] - rs0)), 0);
      ready0 = 1'b0;
      send_frame(0, 9'h077, 8, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(0, 1);
      check("t5_pre_valid", 32'(rx_valid0), 1);
      fork
         send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
         begin
            repeat (5*DIV) @(negedge clk_r);
            rst_n = 1'b0;
            repeat (2) @(negedge clk_r);
            check("t5_rst_valid", 32'(rx_valid0), 0);
            check("t5_rst_data", 32'(rx_data0), 0);
            check("t5_rst_busy", 32'(busy0), 0);
            check("t5_rst_flags", 32'({frame_err0, overrun0, rx_perr0}), 0);
         end
      join
      idle_bits(0, 1);
      rst_n  = 1'b1;
      ready0 = 1'b1;
      idle_bits(0, 1);
      check("t5_post_busy", 32'(busy0), 0);
      fe0 = fe_cnt[0]; ov0 = ov_cnt[0];
      send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(0, 2);
      check("t5_qsize", 32'(q0.size()), 1);
      if (q0.size() > 0) begin
         w = q0.pop_front();
         check("t5_data", 32'(w[8:0]), 32'h0C3);
         check("t5_perr", 32'(w[9]), 0);
      end
      check("t5_flags", 32'((fe_cnt[0] - fe0) + (ov_cnt[0] - ov0)), 0);

      // 6: 7 data bits, odd parity, 2 stop bits, 16 back-to-back random words
      for (int i = 0; i < 16; i++) begin
         exp_w[i] = 7'($urandom_range(0, 127));
         send_frame(2, {2'b00, exp_w[i]}, 7, 1'b1, ~(^exp_w[i]), 2, 1'b1);
      end
      idle_bits(2, 2);
      check("t6_qsize", 32'(q2.size()), 16);
      for (int i = 0; i < 16; i++) begin
         if (q2.size() > 0) begin
            w = q2.pop_front();
            check($sformatf("t6_data%0d", i), 32'(w[8:0]), 32'(exp_w[i]));
            check($sformatf("t6_perr%0d", i), 32'(w[9]), 0);
         end
      end
      check("t6_ferr", 32'(fe_cnt[2]), 0);
      check("t6_ovr", 32'(ov_cnt[2]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
